// File: rtl/dbg_cmd_exec.sv
// Debugger command executor: decodes host commands, runs posted word accesses on the CPU bus, drives halt/step.
// Result registered one cycle after host_en; a READ/WRITE arriving while an access is in flight is dropped and flagged.
module dbg_cmd_exec #(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [7:0]  DBG_ID  = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_host_cmd,
    input  logic [31:0] i_host_param,
    input  logic        i_host_en,
    output logic [31:0] o_host_result,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack,
    output logic        o_cpu_halt,
    input  logic        i_cpu_halted,
    output logic        o_cpu_step
);

    localparam logic [7:0]  C_STATUS   = 8'h00;
    localparam logic [7:0]  C_FETCH    = 8'h01;
    localparam logic [7:0]  C_HALT     = 8'h02;
    localparam logic [7:0]  C_RESUME   = 8'h03;
    localparam logic [7:0]  C_STEP     = 8'h04;
    localparam logic [7:0]  C_CLR_ERR  = 8'h05;
    localparam logic [7:0]  C_READ     = 8'h06;
    localparam logic [7:0]  C_SET_ADDR = 8'h80;
    localparam logic [7:0]  C_WRITE    = 8'h81;
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_rdata_buf;
    logic        r_err_timeout;
    logic        r_err_busy;
    logic        r_err_cmd;
    logic [15:0] r_cnt;
    logic [31:0] r_host_result;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic        r_cpu_halt;
    logic        r_cpu_step;

    logic        w_busy;
    logic [31:0] w_status;

    assign w_busy   = (r_state == S_REQ);
    assign w_status = {16'h0000, DBG_ID, 2'b00, i_cpu_halted, r_cpu_halt,
                       r_err_cmd, r_err_busy, r_err_timeout, w_busy};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_addr        <= 32'h0;
            r_rdata_buf   <= 32'h0;
            r_err_timeout <= 1'b0;
            r_err_busy    <= 1'b0;
            r_err_cmd     <= 1'b0;
            r_cnt         <= 16'h0;
            r_host_result <= 32'h0;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= 32'h0;
            r_bus_wdata   <= 32'h0;
            r_cpu_halt    <= 1'b0;
            r_cpu_step    <= 1'b0;
        end else begin
            r_cpu_step <= 1'b0;
            if (i_host_en) begin
                r_host_result <= (i_host_cmd == C_FETCH) ? r_rdata_buf : w_status;
                case (i_host_cmd)
                    C_STATUS, C_FETCH: ;
                    C_HALT:     r_cpu_halt <= 1'b1;
                    C_RESUME:   r_cpu_halt <= 1'b0;
                    C_STEP:     if (r_cpu_halt && i_cpu_halted) r_cpu_step <= 1'b1;
                    C_CLR_ERR: begin
                        r_err_timeout <= 1'b0;
                        r_err_busy    <= 1'b0;
                        r_err_cmd     <= 1'b0;
                    end
                    C_READ, C_WRITE: begin
                        if (w_busy) begin
                            r_err_busy <= 1'b1;
                        end else begin
                            r_state    <= S_REQ;
                            r_bus_req  <= 1'b1;
                            r_bus_we   <= (i_host_cmd == C_WRITE);
                            r_bus_addr <= r_addr;
                            r_cnt      <= 16'h0;
                            if (i_host_cmd == C_WRITE) r_bus_wdata <= i_host_param;
                        end
                    end
                    C_SET_ADDR: r_addr <= {i_host_param[31:2], 2'b00};
                    default:    r_err_cmd <= 1'b1;
                endcase
            end
            // Bus completion is evaluated after decode so a timeout beats a same-cycle CLR_ERR.
            if (r_state == S_REQ) begin
                if (i_bus_ack) begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                    r_addr    <= r_bus_addr + 32'd4;
                    if (!r_bus_we) r_rdata_buf <= i_bus_rdata;
                end else if (r_cnt == TO_LAST) begin
                    r_state       <= S_IDLE;
                    r_bus_req     <= 1'b0;
                    r_err_timeout <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

    assign o_host_result = r_host_result;
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_cpu_halt    = r_cpu_halt;
    assign o_cpu_step    = r_cpu_step;

endmodule

// File: tb/tb_dbg_cmd_exec.sv
// Directed bench for dbg_cmd_exec: drives commands and bus acks on negedges, samples outputs on negedges.
module tb_dbg_cmd_exec;

    logic        clk;
    logic        rst;
    logic [7:0]  host_cmd;
    logic [31:0] host_param;
    logic        host_en;
    logic [31:0] host_result;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        cpu_halt;
    logic        cpu_halted;
    logic        cpu_step;

    int n_checks = 0;
    int n_pass   = 0;

    dbg_cmd_exec #(.TIMEOUT(255), .DBG_ID(8'hA5)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_host_cmd   (host_cmd),
        .i_host_param (host_param),
        .i_host_en    (host_en),
        .o_host_result(host_result),
        .o_bus_req    (bus_req),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .i_bus_rdata  (bus_rdata),
        .i_bus_ack    (bus_ack),
        .o_cpu_halt   (cpu_halt),
        .i_cpu_halted (cpu_halted),
        .o_cpu_step   (cpu_step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One-cycle command strobe; returns on the negedge where the result is visible.
    task automatic cmd(input logic [7:0] c, input logic [31:0] p);
        @(negedge clk);
        host_cmd   = c;
        host_param = p;
        host_en    = 1'b1;
        @(negedge clk);
        host_en    = 1'b0;
    endtask

    // Waits `dly` cycles then pulses bus_ack with rdata; returns where bus_req should be low.
    task automatic ack_after(input int dly, input logic [31:0] rd);
        repeat (dly) @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = rd;
        @(negedge clk);
        bus_ack   = 1'b0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1; host_cmd = 8'h00; host_param = 32'h0; host_en = 1'b0;
        bus_rdata = 32'h0; bus_ack = 1'b0; cpu_halted = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", host_result, 32'h0);
        chk("rst_req",    {31'h0, bus_req}, 32'h0);
        chk("rst_we",     {31'h0, bus_we}, 32'h0);
        chk("rst_addr",   bus_addr, 32'h0);
        chk("rst_wdata",  bus_wdata, 32'h0);
        chk("rst_halt",   {31'h0, cpu_halt}, 32'h0);
        chk("rst_step",   {31'h0, cpu_step}, 32'h0);
        rst = 1'b0;
        cmd(8'h00, 32'h0);
        chk("status_idle", host_result, 32'h0000A500);

        // T1: write with unaligned address, then auto-increment
        cmd(8'h80, 32'h00001003);
        cmd(8'h81, 32'hDEADBEEF);
        chk("t1_req",   {31'h0, bus_req}, 32'h1);
        chk("t1_addr",  bus_addr, 32'h00001000);
        chk("t1_we",    {31'h0, bus_we}, 32'h1);
        chk("t1_wdata", bus_wdata, 32'hDEADBEEF);
        ack_after(2, 32'h0);
        chk("t1_req_drop", {31'h0, bus_req}, 32'h0);
        cmd(8'h00, 32'h0);
        chk("t1_status", host_result, 32'h0000A500);
        cmd(8'h81, 32'h11111111);
        chk("t1_next_addr", bus_addr, 32'h00001004);
        ack_after(1, 32'h0);

        // T2: posted read, STATUS coincident with ack sees pre-ack state
        cmd(8'h80, 32'h00002000);
        cmd(8'h06, 32'h0);
        chk("t2_we",   {31'h0, bus_we}, 32'h0);
        chk("t2_addr", bus_addr, 32'h00002000);
        repeat (4) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        host_cmd = 8'h00; host_en = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0; host_en = 1'b0;
        chk("t2_status_at_ack", host_result, 32'h0000A501);
        chk("t2_req_drop", {31'h0, bus_req}, 32'h0);
        cmd(8'h01, 32'h0);
        chk("t2_fetch", host_result, 32'h12345678);
        cmd(8'h06, 32'h0);
        chk("t2_next_addr", bus_addr, 32'h00002004);
        ack_after(0, 32'hCAFEF00D);
        cmd(8'h01, 32'h0);
        chk("t2_fetch2", host_result, 32'hCAFEF00D);

        // T3: timeout after 255 cycles of bus_req
        cmd(8'h80, 32'h00003000);
        cmd(8'h06, 32'h0);
        cyc = 0;
        while (bus_req && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        chk("t3_req_cycles", cyc, 32'd255);
        cmd(8'h00, 32'h0);
        chk("t3_status_to", host_result, 32'h0000A502);
        cmd(8'h01, 32'h0);
        chk("t3_buf_kept", host_result, 32'hCAFEF00D);
        cmd(8'h05, 32'h0);
        cmd(8'h00, 32'h0);
        chk("t3_status_clr", host_result, 32'h0000A500);
        cmd(8'h06, 32'h0);
        chk("t3_addr_kept", bus_addr, 32'h00003000);
        ack_after(0, 32'h0);

        // T4: second READ while busy is dropped and flagged
        cmd(8'h80, 32'h00004000);
        cmd(8'h06, 32'h0);
        cmd(8'h06, 32'h0);
        chk("t4_status_busy", host_result, 32'h0000A501);
        chk("t4_addr_same", bus_addr, 32'h00004000);
        ack_after(1, 32'h0);
        repeat (3) @(negedge clk);
        chk("t4_single_access", {31'h0, bus_req}, 32'h0);
        cmd(8'h00, 32'h0);
        chk("t4_err_busy", host_result, 32'h0000A504);
        cmd(8'h05, 32'h0);

        // T5: halt / step / resume
        cmd(8'h02, 32'h0);
        chk("t5_halt", {31'h0, cpu_halt}, 32'h1);
        cpu_halted = 1'b1;
        cmd(8'h00, 32'h0);
        chk("t5_status_halted", host_result, 32'h0000A530);
        cmd(8'h04, 32'h0);
        chk("t5_step_pulse", {31'h0, cpu_step}, 32'h1);
        @(negedge clk);
        chk("t5_step_end", {31'h0, cpu_step}, 32'h0);
        cmd(8'h03, 32'h0);
        chk("t5_resume", {31'h0, cpu_halt}, 32'h0);
        cmd(8'h04, 32'h0);
        chk("t5_no_step", {31'h0, cpu_step}, 32'h0);
        cpu_halted = 1'b0;

        // T6: address wrap, reset mid-access, illegal command
        cmd(8'h80, 32'hFFFFFFFC);
        cmd(8'h81, 32'h00000055);
        chk("t6_top_addr", bus_addr, 32'hFFFFFFFC);
        ack_after(1, 32'h0);
        cmd(8'h06, 32'h0);
        chk("t6_wrap_addr", bus_addr, 32'h00000000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_req", {31'h0, bus_req}, 32'h0);
        ack_after(0, 32'h00000BAD);
        chk("t6_late_ack_req", {31'h0, bus_req}, 32'h0);
        cmd(8'h00, 32'h0);
        chk("t6_status_after_rst", host_result, 32'h0000A500);
        cmd(8'h01, 32'h0);
        chk("t6_buf_after_rst", host_result, 32'h0);
        cmd(8'h7F, 32'h0);
        cmd(8'h00, 32'h0);
        chk("t6_err_cmd", host_result, 32'h0000A508);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
